// File: rtl/uart_rx_port.sv
// uart_rx_port
// Memory-mapped UART receiver for the LC3 I/O space. It deserializes 8N1 or
// 8-bit-plus-parity frames from rxd. The received byte is held in UARTRDR.
// Ready, interrupt-enable, overrun, parity-error and framing-error flags are
// held in UARTRSR.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   rxd                 serial line (idles high, asynchronous to clk)
//   parity_en           frame carries a parity bit after the data bits
//   parity_kind         0 = even parity, 1 = odd parity
//   MDR                 write data for UARTRSR
//   LD_UARTRSR          status-register write strobe
//   RD_UARTRDR          CPU read of UARTRDR (clears ready and error flags)
//   UARTRDR             {8'h00, received byte}
//   UARTRSR             {ready, ie, overrun, parity err, framing err, 11'b0}
//   IRQ                 ready & interrupt enable
//   rx_busy             receiver FSM is not idle
module uart_rx_port #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  input  logic        parity_en,
  input  logic        parity_kind,
  input  logic [15:0] MDR,
  input  logic        LD_UARTRSR,
  input  logic        RD_UARTRDR,
  output logic [15:0] UARTRDR,
  output logic [15:0] UARTRSR,
  output logic        IRQ,
  output logic        rx_busy
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_e;

  logic          sync1_q, sync2_q, sync3_q;
  logic [1:0]    warm_q;
  logic          armed_q;
  logic          rxS, fallEdge;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          parErr_q;

  logic          deliver, stopErr;
  logic          rdy_q, ie_q, ovr_q, perr_q, ferr_q;
  logic          rdy_d, ie_d, ovr_d, perr_d, ferr_d;
  logic [7:0]    rdr_q, rdr_d;

  logic          unusedMdr;
  assign unusedMdr = ^{MDR[15], MDR[10:0]};

  // The synchronizer flops reset to 1. A line that is already low when
  // reset is released would otherwise look like a falling edge. Start
  // detection is therefore armed only after the synchronized line has been
  // seen high once the flops hold real samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
      warm_q  <= 2'd0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
      if (warm_q >= 2'd2 && sync2_q) armed_q <= 1'b1;
    end
  end

  assign rxS      = sync2_q;
  assign fallEdge = armed_q & sync3_q & ~sync2_q;

  // Frame FSM: cnt_q counts clocks down to the next sample point. The first
  // load of half a bit period centres every later sample inside its bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      parErr_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fallEdge) begin
            cnt_q   <= HALF;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == '0) begin
            if (rxS) begin
              state_q <= S_IDLE;
            end else begin
              cnt_q    <= FULL;
              idx_q    <= 3'd0;
              parErr_q <= 1'b0;
              state_q  <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {rxS, shift_q[7:1]};
            cnt_q   <= FULL;
            if (idx_q == 3'd7) state_q <= parity_en ? S_PARITY : S_STOP;
            else               idx_q   <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_PARITY: begin
          if (cnt_q == '0) begin
            parErr_q <= ((^shift_q) ^ rxS) != parity_kind;
            cnt_q    <= FULL;
            state_q  <= S_STOP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == '0) state_q <= rxS ? S_IDLE : S_BREAK;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        S_BREAK: begin
          if (rxS) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Delivery coincides with the stop-bit sample edge. Ready is therefore
  // visible in the cycle after the stop sample.
  assign deliver = (state_q == S_STOP) && (cnt_q == '0);
  assign stopErr = ~rxS;

  // Status update ordering: a CPU read clears first. Software writes apply
  // next. Delivery applies last, so its error bits override a
  // write-1-to-clear, and a read in the same cycle avoids an overrun.
  always_comb begin
    rdy_d  = rdy_q;
    ie_d   = ie_q;
    ovr_d  = ovr_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    rdr_d  = rdr_q;
    if (RD_UARTRDR) begin
      rdy_d  = 1'b0;
      ovr_d  = 1'b0;
      perr_d = 1'b0;
      ferr_d = 1'b0;
    end
    if (LD_UARTRSR) begin
      ie_d = MDR[14];
      if (MDR[13]) ovr_d  = 1'b0;
      if (MDR[12]) perr_d = 1'b0;
      if (MDR[11]) ferr_d = 1'b0;
    end
    if (deliver) begin
      if (!rdy_d) begin
        rdr_d  = shift_q;
        rdy_d  = 1'b1;
        perr_d = perr_d | parErr_q;
        ferr_d = ferr_d | stopErr;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // Status and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q  <= 1'b0;
      ie_q   <= 1'b0;
      ovr_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      rdr_q  <= 8'h00;
    end else begin
      rdy_q  <= rdy_d;
      ie_q   <= ie_d;
      ovr_q  <= ovr_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      rdr_q  <= rdr_d;
    end
  end

  assign UARTRDR = {8'h00, rdr_q};
  assign UARTRSR = {rdy_q, ie_q, ovr_q, perr_q, ferr_q, 11'b0};
  assign IRQ     = rdy_q & ie_q;
  assign rx_busy = (state_q != S_IDLE);

endmodule
